// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers a payload from a byte stream, then sends header, payload
// and XOR parity bytes to the router input, holding each byte while busy is high.
module router_pkt_tx #(
    parameter int MAX_LEN = 63
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       i_cmd_valid,
    input  logic [1:0] i_cmd_dest,
    input  logic [5:0] i_cmd_len,
    output logic       o_cmd_ready,
    output logic       o_cmd_err,
    input  logic       i_s_valid,
    input  logic [7:0] i_s_data,
    output logic       o_s_ready,
    input  logic       i_busy,
    output logic       o_pkt_valid,
    output logic [7:0] o_data_out,
    output logic       o_done
);
    typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP} state_t;
    state_t     r_state, w_next;
    logic [1:0] r_dest;
    logic [5:0] r_len, r_cnt;
    logic [7:0] r_parity;
    logic [7:0] r_buf [MAX_LEN];
    logic       w_cmd_ok, w_s_acc, w_last, w_xfer;
    always_comb begin
        o_cmd_ready = r_state == IDLE;
        o_s_ready   = r_state == LOAD;
        w_cmd_ok    = i_cmd_valid & o_cmd_ready & (i_cmd_dest != 2'd3);
        w_s_acc     = i_s_valid & o_s_ready;
        w_last      = r_cnt == r_len - 6'd1;
        w_xfer      = ~i_busy;
        w_next      = r_state;
        case (r_state)
            IDLE:    if (w_cmd_ok) w_next = (i_cmd_len != 6'd0) ? LOAD : HEADER;
            LOAD:    if (w_s_acc && w_last) w_next = HEADER;
            HEADER:  if (w_xfer) w_next = (r_len != 6'd0) ? PAYLOAD : PARITY;
            PAYLOAD: if (w_xfer && w_last) w_next = PARITY;
            PARITY:  if (w_xfer) w_next = GAP;
            GAP:     if (w_xfer) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clock)
        r_state <= resetn ? w_next : IDLE;
    // payload storage is deliberately left out of reset
    always_ff @(posedge clock)
        if (w_s_acc) r_buf[r_cnt] <= i_s_data;
    always_ff @(posedge clock) begin
        if (!resetn) begin
            o_pkt_valid <= 1'b0;
            o_data_out  <= 8'h00;
            o_done      <= 1'b0;
            o_cmd_err   <= 1'b0;
            r_dest      <= 2'd0;
            r_len       <= 6'd0;
            r_cnt       <= 6'd0;
            r_parity    <= 8'h00;
        end else begin
            o_done    <= 1'b0;
            o_cmd_err <= 1'b0;
            case (r_state)
                IDLE: if (i_cmd_valid) begin
                    if (i_cmd_dest == 2'd3) begin
                        o_cmd_err <= 1'b1;
                    end else begin
                        r_dest   <= i_cmd_dest;
                        r_len    <= i_cmd_len;
                        r_parity <= {i_cmd_len, i_cmd_dest};
                        r_cnt    <= 6'd0;
                        if (i_cmd_len == 6'd0) begin
                            o_pkt_valid <= 1'b1;
                            o_data_out  <= {i_cmd_len, i_cmd_dest};
                        end
                    end
                end
                LOAD: if (i_s_valid) begin
                    r_parity <= r_parity ^ i_s_data;
                    r_cnt    <= r_cnt + 6'd1;
                    if (w_last) begin
                        o_pkt_valid <= 1'b1;
                        o_data_out  <= {r_len, r_dest};
                    end
                end
                HEADER: if (w_xfer) begin
                    if (r_len != 6'd0) begin
                        o_data_out <= r_buf[0];
                        r_cnt      <= 6'd0;
                    end else begin
                        o_pkt_valid <= 1'b0;
                        o_data_out  <= r_parity;
                    end
                end
                PAYLOAD: if (w_xfer) begin
                    if (!w_last) begin
                        r_cnt      <= r_cnt + 6'd1;
                        o_data_out <= r_buf[r_cnt + 6'd1];
                    end else begin
                        o_pkt_valid <= 1'b0;
                        o_data_out  <= r_parity;
                    end
                end
                PARITY: if (w_xfer) o_data_out <= 8'h00;
                GAP:    if (w_xfer) o_done <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule
